// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch, load and store requesters of a multicycle cpu.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise priority is fixed at st > ld > if.
module mem_port_arbiter #(
    parameter int W        = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [W-1:0] if_addr,
    output logic         if_ack,
    output logic [W-1:0] if_rdata,
    input  logic         ld_req,
    input  logic [W-1:0] ld_addr,
    output logic         ld_ack,
    output logic [W-1:0] ld_rdata,
    input  logic         st_req,
    input  logic [W-1:0] st_addr,
    input  logic [W-1:0] st_data,
    output logic         st_ack,
    output logic         m_req,
    output logic         m_we,
    output logic [W-1:0] m_addr,
    output logic [W-1:0] m_wdata,
    input  logic         m_ready,
    input  logic [W-1:0] m_rdata,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IF   = 2'b01;
    localparam logic [1:0] G_LD   = 2'b10;
    localparam logic [1:0] G_ST   = 2'b11;

    // The abort fires on the edge that would take the counter to MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t         state_q;
    logic [7:0]     cnt_q;
    logic [7:0]     cnt_d;
    logic           timeout_s;
    logic [1:0]     win_s;
    logic [2:0]     req_s;

    logic           if_ack_q;
    logic           ld_ack_q;
    logic           st_ack_q;
    logic [W-1:0]   if_rdata_q;
    logic [W-1:0]   ld_rdata_q;
    logic           m_req_q;
    logic           m_we_q;
    logic [W-1:0]   m_addr_q;
    logic [W-1:0]   m_wdata_q;
    logic [1:0]     grant_q;
    logic           busy_q;
    logic           timeout_err_q;

    assign req_s = {st_req, ld_req, if_req};

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    logic [1:0] c0_s;
    logic [1:0] c1_s;
    logic [1:0] c2_s;

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            G_IF:    n = G_LD;
            G_LD:    n = G_ST;
            G_ST:    n = G_IF;
            default: n = G_IF;
        endcase
        return n;
    endfunction

    function automatic logic req_of(input logic [1:0] g, input logic [2:0] r);
        logic v;
        case (g)
            G_IF:    v = r[0];
            G_LD:    v = r[1];
            G_ST:    v = r[2];
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Rotating search starting just after the last granted requester.
    always_comb begin
        c0_s  = rr_next(ptr_q);
        c1_s  = rr_next(c0_s);
        c2_s  = rr_next(c1_s);
        win_s = G_NONE;
        if (req_of(c0_s, req_s)) begin
            win_s = c0_s;
        end else if (req_of(c1_s, req_s)) begin
            win_s = c1_s;
        end else if (req_of(c2_s, req_s)) begin
            win_s = c2_s;
        end else begin
            win_s = G_NONE;
        end
    end
`else
    // Fixed priority: store first, then load, then fetch.
    always_comb begin
        win_s = G_NONE;
        if (req_s[2]) begin
            win_s = G_ST;
        end else if (req_s[1]) begin
            win_s = G_LD;
        end else if (req_s[0]) begin
            win_s = G_IF;
        end else begin
            win_s = G_NONE;
        end
    end
`endif

    // Watchdog: next count value and abort detection while a transaction waits.
    always_comb begin
        cnt_d     = cnt_q + 8'd1;
        timeout_s = 1'b0;
        if (state_q == S_BUSY) begin
            timeout_s = (cnt_q == WAIT_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Transaction sequencer; every output comes straight from a register here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            if_ack_q      <= 1'b0;
            ld_ack_q      <= 1'b0;
            st_ack_q      <= 1'b0;
            if_rdata_q    <= {W{1'b0}};
            ld_rdata_q    <= {W{1'b0}};
            m_req_q       <= 1'b0;
            m_we_q        <= 1'b0;
            m_addr_q      <= {W{1'b0}};
            m_wdata_q     <= {W{1'b0}};
            grant_q       <= G_NONE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q         <= G_IF;
`endif
        end else begin
            if_ack_q <= 1'b0;
            ld_ack_q <= 1'b0;
            st_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_s != G_NONE) begin
                        state_q   <= S_BUSY;
                        cnt_q     <= 8'd0;
                        m_req_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        grant_q   <= win_s;
                        m_we_q    <= (win_s == G_ST);
                        m_wdata_q <= (win_s == G_ST) ? st_data : {W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_q     <= win_s;
`endif
                        case (win_s)
                            G_IF:    m_addr_q <= if_addr;
                            G_LD:    m_addr_q <= ld_addr;
                            G_ST:    m_addr_q <= st_addr;
                            default: m_addr_q <= m_addr_q;
                        endcase
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (m_ready || timeout_s) begin
                        state_q   <= S_DONE;
                        cnt_q     <= 8'd0;
                        m_req_q   <= 1'b0;
                        m_we_q    <= 1'b0;
                        m_wdata_q <= {W{1'b0}};
                        grant_q   <= G_NONE;
                        busy_q    <= 1'b0;
                        // A late m_ready on the abort edge still counts as success.
                        if (!m_ready) begin
                            timeout_err_q <= 1'b1;
                        end else begin
                            timeout_err_q <= timeout_err_q;
                        end
                        case (grant_q)
                            G_IF: begin
                                if_ack_q   <= 1'b1;
                                if_rdata_q <= m_ready ? m_rdata : {W{1'b0}};
                            end
                            G_LD: begin
                                ld_ack_q   <= 1'b1;
                                ld_rdata_q <= m_ready ? m_rdata : {W{1'b0}};
                            end
                            G_ST: begin
                                st_ack_q <= 1'b1;
                            end
                            default: begin
                                st_ack_q <= 1'b0;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ack      = if_ack_q;
    assign ld_ack      = ld_ack_q;
    assign st_ack      = st_ack_q;
    assign if_rdata    = if_rdata_q;
    assign ld_rdata    = ld_rdata_q;
    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected transactions are queued
// when requests are raised and compared as the memory side and acks respond.
module tb_mem_port_arbiter;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IF   = 2'b01;
    localparam logic [1:0] G_LD   = 2'b10;
    localparam logic [1:0] G_ST   = 2'b11;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ld_req, st_req, m_ready;
    logic [31:0] if_addr, ld_addr, st_addr, st_data, m_rdata;
    logic        if_ack, ld_ack, st_ack, m_req, m_we, busy, timeout_err;
    logic [31:0] if_rdata, ld_rdata, m_addr, m_wdata;
    logic [1:0]  grant;

    int   tests = 0;
    int   fails = 0;
    logic exp_terr = 1'b0;
    exp_t exp_q[$];
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_g = G_IF;
`endif

    mem_port_arbiter #(.W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Invariants sampled mid-cycle: at most one ack, and writes only under a store grant.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("one_ack", 32'($countones({st_ack, ld_ack, if_ack}) <= 1), 32'd1);
            check("we_only_st", 32'(!m_we || (grant == G_ST)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] g);
        logic [2:0] v;
        case (g)
            G_IF:    v = 3'b001;
            G_LD:    v = 3'b010;
            G_ST:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    task automatic push_exp(input logic [1:0] g, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        e.grant = g; e.addr = a; e.we = we; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
`ifdef ARB_ROUND_ROBIN_EN
        last_g = g;
`endif
    endtask

    task automatic drop(input logic [1:0] g);
        case (g)
            G_IF:    if_req = 1'b0;
            G_LD:    ld_req = 1'b0;
            G_ST:    st_req = 1'b0;
            default: begin if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; end
        endcase
    endtask

    // Waits for the grant, checks the memory-side request, answers after lat edges and checks the ack.
    // mode: 0 keep req, 1 drop after ack, 2 drop right after grant, 3 drop all after ack.
    task automatic run_txn(input int lat, input logic [31:0] rd, input int mode);
        exp_t e;
        int   n;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin tick(); n++; end
        check("m_req_rise", 32'(m_req), 32'd1);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("busy_on", 32'(busy), 32'd1);
            check("m_addr", m_addr, e.addr);
            check("m_we", 32'(m_we), 32'(e.we));
            check("m_wdata", m_wdata, e.wdata);
            if (mode == 2) drop(e.grant);
            repeat (lat - 1) tick();
            check("grant_hold", 32'(grant), 32'(e.grant));
            check("no_early_ack", 32'({st_ack, ld_ack, if_ack}), 32'd0);
            m_ready = 1'b1; m_rdata = rd;
            tick();
            m_ready = 1'b0; m_rdata = 32'd0;
            check("ack", 32'({st_ack, ld_ack, if_ack}), 32'(onehot(e.grant)));
            check("m_req_fall", 32'(m_req), 32'd0);
            check("terr", 32'(timeout_err), 32'(exp_terr));
            if (e.grant == G_IF) check("if_rdata", if_rdata, e.rdata);
            if (e.grant == G_LD) check("ld_rdata", ld_rdata, e.rdata);
            if (mode == 1) drop(e.grant);
            if (mode == 3) drop(G_NONE);
            tick();
            check("ack_pulse", 32'({st_ack, ld_ack, if_ack}), 32'd0);
            check("done_grant", 32'(grant), 32'(G_NONE));
            check("done_busy", 32'(busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; m_ready = 1'b0;
        if_addr = 32'd0; ld_addr = 32'd0; st_addr = 32'd0; st_data = 32'd0; m_rdata = 32'd0;

        #12;
        check("rst_outputs", 32'({if_ack, ld_ack, st_ack, m_req, m_we, busy, timeout_err, grant}), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        tick();

        // Single fetch answered two cycles after m_req.
        if_addr = 32'h0040_0000;
        push_exp(G_IF, 32'h0040_0000, 1'b0, 32'd0, 32'h2408_0005);
        if_req = 1'b1;
        run_txn(2, 32'h2408_0005, 1);

        // Simultaneous requests served in fixed priority order.
        st_addr = 32'h1001_0000; st_data = 32'hDEAD_BEEF;
        ld_addr = 32'h1001_0004; if_addr = 32'h0040_0004;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(G_LD, 32'h1001_0004, 1'b0, 32'd0, 32'h1111_2222);
        push_exp(G_ST, 32'h1001_0000, 1'b1, 32'hDEAD_BEEF, 32'd0);
        push_exp(G_IF, 32'h0040_0004, 1'b0, 32'd0, 32'h3333_4444);
        st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
        run_txn(1, 32'h1111_2222, 1);
        run_txn(1, 32'h0BAD_0BAD, 1);
`else
        push_exp(G_ST, 32'h1001_0000, 1'b1, 32'hDEAD_BEEF, 32'd0);
        push_exp(G_LD, 32'h1001_0004, 1'b0, 32'd0, 32'h1111_2222);
        push_exp(G_IF, 32'h0040_0004, 1'b0, 32'd0, 32'h3333_4444);
        st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
        run_txn(1, 32'h0BAD_0BAD, 1);
        run_txn(1, 32'h1111_2222, 1);
`endif
        run_txn(1, 32'h3333_4444, 1);

        // Spurious m_ready in IDLE is ignored.
        m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("idle_spurious", 32'({st_ack, ld_ack, if_ack, m_req, grant}), 32'd0);
        check("idle_if_rdata_hold", if_rdata, 32'h3333_4444);
        m_ready = 1'b0; m_rdata = 32'd0;

        // Store whose req is dropped mid-BUSY still completes and acks.
        st_addr = 32'h1001_0010; st_data = 32'h0123_4567;
        push_exp(G_ST, 32'h1001_0010, 1'b1, 32'h0123_4567, 32'd0);
        st_req = 1'b1;
        run_txn(3, 32'd0, 2);

        // m_ready on the same edge as the watchdog limit wins.
        ld_addr = 32'h1001_0020;
        push_exp(G_LD, 32'h1001_0020, 1'b0, 32'd0, 32'h5555_6666);
        ld_req = 1'b1;
        run_txn(15, 32'h5555_6666, 1);

        // Watchdog abort on a load.
        ld_addr = 32'h1001_0008;
        push_exp(G_LD, 32'h1001_0008, 1'b0, 32'd0, 32'd0);
        ld_req = 1'b1;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin tick(); n++; end
        e = exp_q.pop_front();
        check("to_grant", 32'(grant), 32'(e.grant));
        check("to_m_addr", m_addr, e.addr);
        n = 0;
        while (m_req === 1'b1 && n < 40) begin tick(); n++; end
        check("to_busy_cycles", 32'(n), 32'd15);
        exp_terr = 1'b1;
        check("to_ld_ack", 32'({st_ack, ld_ack, if_ack}), 32'b010);
        check("to_ld_rdata", ld_rdata, e.rdata);
        check("to_err_set", 32'(timeout_err), 32'(exp_terr));
        ld_req = 1'b0;
        tick();
        check("to_ack_pulse", 32'(ld_ack), 32'd0);
        repeat (3) tick();
        check("to_err_sticky", 32'(timeout_err), 32'(exp_terr));

        // Asynchronous reset in the middle of a transaction.
        ld_addr = 32'h1001_0030;
        ld_req = 1'b1;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin tick(); n++; end
        check("rst_mid_pre", 32'(busy), 32'd1);
        tick();
        #2 rst = 1'b0;
        #1;
        exp_terr = 1'b0;
        check("rst_mid_outputs", 32'({m_req, grant, busy, if_ack, ld_ack, st_ack}), 32'd0);
        check("rst_mid_terr", 32'(timeout_err), 32'(exp_terr));
        check("rst_mid_rdata", ld_rdata, 32'd0);
        ld_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        last_g = G_IF;
`endif
        tick();
        if_addr = 32'h0040_0100;
        push_exp(G_IF, 32'h0040_0100, 1'b0, 32'd0, 32'h7777_8888);
        if_req = 1'b1;
        run_txn(2, 32'h7777_8888, 1);

        // Fetch and load held continuously.
        if_addr = 32'h0040_0200; ld_addr = 32'h1001_0040;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            if (last_g == G_IF) push_exp(G_LD, 32'h1001_0040, 1'b0, 32'd0, 32'(i + 100));
            else                push_exp(G_IF, 32'h0040_0200, 1'b0, 32'd0, 32'(i + 100));
        end
        if_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 4; i++) run_txn(1, 32'(i + 100), (i == 3) ? 3 : 0);
`else
        for (int i = 0; i < 3; i++) push_exp(G_LD, 32'h1001_0040, 1'b0, 32'd0, 32'(i + 100));
        push_exp(G_IF, 32'h0040_0200, 1'b0, 32'd0, 32'd103);
        if_req = 1'b1; ld_req = 1'b1;
        run_txn(1, 32'd100, 0);
        run_txn(1, 32'd101, 0);
        run_txn(1, 32'd102, 1);
        run_txn(1, 32'd103, 3);
`endif

        repeat (2) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("end_idle", 32'({m_req, busy, grant}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
